// File: rtl/vga_pkg.sv
// Shared VGA raster timing: default 640x480@60 constants, derived totals and sync windows,
// plus a timing-struct so alternate modes can be described as a single constant later.
package vga_pkg;

  localparam int unsigned COUNTER_W = 10;
  localparam int unsigned MAX_TOTAL = 1 << COUNTER_W;

  localparam int unsigned DEF_CLK_DIV  = 2;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_SYNC_POL = 0;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync windows are half-open: [START, END)
  localparam int unsigned DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int unsigned DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  typedef struct packed {
    logic [COUNTER_W-1:0] active;
    logic [COUNTER_W-1:0] fp;
    logic [COUNTER_W-1:0] sync;
    logic [COUNTER_W-1:0] bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
    logic         sync_pol;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h: '{active: COUNTER_W'(DEF_H_ACTIVE), fp: COUNTER_W'(DEF_H_FP),
         sync: COUNTER_W'(DEF_H_SYNC), bp: COUNTER_W'(DEF_H_BP)},
    v: '{active: COUNTER_W'(DEF_V_ACTIVE), fp: COUNTER_W'(DEF_V_FP),
         sync: COUNTER_W'(DEF_V_SYNC), bp: COUNTER_W'(DEF_V_BP)},
    sync_pol: 1'b0
  };

  function automatic int unsigned axis_total(input axis_timing_t t);
    return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
  endfunction

endpackage

// File: rtl/pixel_clk_en.sv
// Divides CLK into a one-cycle pixel-rate strobe; pix_en is registered and high while the
// divider sits on its last count (constantly high after reset when CLK_DIV is 1).
module pixel_clk_en #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic pix_en
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;

  if (CLK_DIV < 1) begin : g_bad_div
    $error("pixel_clk_en: CLK_DIV must be at least 1");
  end

  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
  end

  // Strobe is registered from the next divider value so it lines up with div==CLK_DIV-1
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      div    <= div_nxt;
      pix_en <= (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel divider, h/v counters, sync pulses and blanking flags.
// Every output is a flop; decodes use next counter values so they stay aligned with row/col.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned SYNC_POL = DEF_SYNC_POL
) (
  input  logic                 CLK,
  input  logic                 RST,
  output logic [COUNTER_W-1:0] row,
  output logic [COUNTER_W-1:0] col,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 vnotactive,
  output logic                 display_en,
  output logic                 pix_en,
  output logic                 frame_start,
  output logic [7:0]           frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CW1     = COUNTER_W + 1;

  localparam logic [COUNTER_W-1:0] H_LAST = COUNTER_W'(H_TOTAL - 1);
  localparam logic [COUNTER_W-1:0] V_LAST = COUNTER_W'(V_TOTAL - 1);

  // One extra bit so a window ending exactly at 1024 still compares correctly
  localparam logic [CW1-1:0] H_ACT    = CW1'(H_ACTIVE);
  localparam logic [CW1-1:0] V_ACT    = CW1'(V_ACTIVE);
  localparam logic [CW1-1:0] HS_START = CW1'(H_ACTIVE + H_FP);
  localparam logic [CW1-1:0] HS_END   = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW1-1:0] VS_START = CW1'(V_ACTIVE + V_FP);
  localparam logic [CW1-1:0] VS_END   = CW1'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = ~SYNC_ON;

  if (H_TOTAL > MAX_TOTAL) begin : g_bad_h_total
    $error("vga_timing_gen: horizontal total exceeds counter range");
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_bad_v_total
    $error("vga_timing_gen: vertical total exceeds counter range");
  end

  logic                 pix_stb;
  logic                 h_last;
  logic                 frame_wrap;
  logic [COUNTER_W-1:0] h_nxt;
  logic [COUNTER_W-1:0] v_nxt;
  logic [CW1-1:0]       h_nxt_x;
  logic [CW1-1:0]       v_nxt_x;
  logic                 hs_on;
  logic                 vs_on;

  pixel_clk_en #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_clk_en (
    .CLK    (CLK),
    .RST    (RST),
    .pix_en (pix_stb)
  );

  always_comb begin
    h_last     = (col == H_LAST);
    frame_wrap = h_last && (row == V_LAST);
    h_nxt      = h_last ? '0 : col + COUNTER_W'(1);
    v_nxt      = row;
    if (h_last) begin
      v_nxt = (row == V_LAST) ? '0 : row + COUNTER_W'(1);
    end
    h_nxt_x = {1'b0, h_nxt};
    v_nxt_x = {1'b0, v_nxt};
    hs_on   = (h_nxt_x >= HS_START) && (h_nxt_x < HS_END);
    vs_on   = (v_nxt_x >= VS_START) && (v_nxt_x < VS_END);
  end

  // row/col are the counters themselves; all decodes update on the same pixel edge
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      col         <= '0;
      row         <= '0;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      vnotactive  <= 1'b0;
      display_en  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= 1'b0;
      if (pix_stb) begin
        col         <= h_nxt;
        row         <= v_nxt;
        hsync       <= hs_on ? SYNC_ON : SYNC_OFF;
        vsync       <= vs_on ? SYNC_ON : SYNC_OFF;
        vnotactive  <= (v_nxt_x >= V_ACT);
        display_en  <= (h_nxt_x < H_ACT) && (v_nxt_x < V_ACT);
        frame_start <= frame_wrap;
        if (frame_wrap) begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  assign pix_en = pix_stb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench on a scaled-down raster (25 px x 15 lines, CLK_DIV=2 -> 750 CLK per frame)
// so whole frames fit in a short run; expected values are hand-derived from the local timing.
module tb_vga_timing_gen;

  localparam int unsigned T_CLK_DIV  = 2;
  localparam int unsigned T_H_ACTIVE = 16;
  localparam int unsigned T_H_FP     = 2;
  localparam int unsigned T_H_SYNC   = 4;
  localparam int unsigned T_H_BP     = 3;   // H total 25, hsync [18,22)
  localparam int unsigned T_V_ACTIVE = 8;
  localparam int unsigned T_V_FP     = 2;
  localparam int unsigned T_V_SYNC   = 2;
  localparam int unsigned T_V_BP     = 3;   // V total 15, vsync [10,12)

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [9:0] row;
  logic [9:0] col;
  logic       hsync;
  logic       vsync;
  logic       vnotactive;
  logic       display_en;
  logic       pix_en;
  logic       frame_start;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(
    .CLK_DIV (T_CLK_DIV),
    .H_ACTIVE(T_H_ACTIVE), .H_FP(T_H_FP), .H_SYNC(T_H_SYNC), .H_BP(T_H_BP),
    .V_ACTIVE(T_V_ACTIVE), .V_FP(T_V_FP), .V_SYNC(T_V_SYNC), .V_BP(T_V_BP),
    .SYNC_POL(0)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .row        (row),
    .col        (col),
    .hsync      (hsync),
    .vsync      (vsync),
    .vnotactive (vnotactive),
    .display_en (display_en),
    .pix_en     (pix_en),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic wait_rc(input logic [9:0] c, input logic [9:0] r, input int budget,
                         output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      if (col === c && row === r) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    checks++; if (row !== 10'd0) begin errors++; $display("FAIL reset_row got %0d exp 0", row); end
    checks++; if (col !== 10'd0) begin errors++; $display("FAIL reset_col got %0d exp 0", col); end
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b exp 1", hsync); end
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b exp 1", vsync); end
    checks++; if (vnotactive !== 1'b0) begin errors++; $display("FAIL reset_vnotactive got %b exp 0", vnotactive); end
    checks++; if (display_en !== 1'b0) begin errors++; $display("FAIL reset_display_en got %b exp 0", display_en); end
    checks++; if (pix_en !== 1'b0) begin errors++; $display("FAIL reset_pix_en got %b exp 0", pix_en); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b exp 0", frame_start); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
  endtask

  task automatic test_first_pixel();
    RST = 1'b1;
    tick();
    checks++; if (pix_en !== 1'b1 || col !== 10'd0) begin
      errors++; $display("FAIL first_strobe pix_en=%b col=%0d exp pix_en=1 col=0", pix_en, col);
    end
    tick();
    checks++; if (col !== 10'd1 || row !== 10'd0 || display_en !== 1'b1 || pix_en !== 1'b0) begin
      errors++; $display("FAIL first_advance col=%0d row=%0d de=%b pix_en=%b exp 1 0 1 0",
                         col, row, display_en, pix_en);
    end
    checks++; if (frame_start !== 1'b0) begin
      errors++; $display("FAIL no_reset_frame_start got %b exp 0", frame_start);
    end
  endtask

  task automatic test_line_timing();
    bit found;
    int n;
    wait_rc(10'd17, 10'd0, 100, found);
    checks++; if (!found || hsync !== 1'b1) begin
      errors++; $display("FAIL hsync_before found=%b hsync=%b exp found=1 hsync=1", found, hsync);
    end
    tick();
    tick();
    checks++; if (col !== 10'd18 || hsync !== 1'b0) begin
      errors++; $display("FAIL hsync_fall col=%0d hsync=%b exp col=18 hsync=0", col, hsync);
    end
    n = 0;
    while (hsync === 1'b0 && n < 50) begin
      tick();
      n++;
    end
    checks++; if (n != 8 || col !== 10'd22) begin
      errors++; $display("FAIL hsync_width clk=%0d col=%0d exp clk=8 col=22", n, col);
    end
    wait_rc(10'd24, 10'd0, 100, found);
    tick();
    tick();
    checks++; if (!found || col !== 10'd0 || row !== 10'd1) begin
      errors++; $display("FAIL line_wrap found=%b col=%0d row=%0d exp 1 0 1", found, col, row);
    end
  endtask

  task automatic test_vblank_vsync();
    bit found;
    bit prev_vs;
    int n, bad, low;
    int fall_row, rise_row;
    wait_rc(10'd24, 10'd7, 400, found);
    checks++; if (!found || vnotactive !== 1'b0) begin
      errors++; $display("FAIL vblank_before found=%b vnotactive=%b exp 1 0", found, vnotactive);
    end
    tick();
    tick();
    checks++; if (row !== 10'd8 || col !== 10'd0 || vnotactive !== 1'b1 || display_en !== 1'b0) begin
      errors++; $display("FAIL vblank_rise row=%0d col=%0d vna=%b de=%b exp 8 0 1 0",
                         row, col, vnotactive, display_en);
    end
    n = 0; bad = 0; low = 0; fall_row = -1; rise_row = -1; prev_vs = vsync;
    while (n < 400) begin
      tick();
      n++;
      if (frame_start === 1'b1) break;
      if (vnotactive !== 1'b1 || display_en !== 1'b0) bad++;
      if (vsync === 1'b0) low++;
      if (prev_vs === 1'b1 && vsync === 1'b0) fall_row = int'(row);
      if (prev_vs === 1'b0 && vsync === 1'b1) rise_row = int'(row);
      prev_vs = vsync;
    end
    checks++; if (bad != 0) begin
      errors++; $display("FAIL vblank_span bad_cycles=%0d exp 0", bad);
    end
    checks++; if (low != 100 || fall_row != 10 || rise_row != 12) begin
      errors++; $display("FAIL vsync_window low_clk=%0d fall_row=%0d rise_row=%0d exp 100 10 12",
                         low, fall_row, rise_row);
    end
    checks++; if (n != 350 || row !== 10'd0 || col !== 10'd0 || frame_cnt !== 8'd1) begin
      errors++; $display("FAIL first_frame clk=%0d row=%0d col=%0d cnt=%0d exp 350 0 0 1",
                         n, row, col, frame_cnt);
    end
    checks++; if (vnotactive !== 1'b0 || display_en !== 1'b1) begin
      errors++; $display("FAIL frame_top vna=%b de=%b exp 0 1", vnotactive, display_en);
    end
  endtask

  task automatic test_frame_rate();
    int n;
    for (int f = 2; f <= 3; f++) begin
      tick();
      checks++; if (frame_start !== 1'b0) begin
        errors++; $display("FAIL frame_start_width frame=%0d got %b exp 0", f, frame_start);
      end
      n = 1;
      while (frame_start !== 1'b1 && n < 1000) begin
        tick();
        n++;
      end
      checks++; if (n != 750 || frame_cnt !== 8'(f)) begin
        errors++; $display("FAIL frame_period frame=%0d clk=%0d cnt=%0d exp clk=750 cnt=%0d",
                           f, n, frame_cnt, f);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    int n;
    wait_rc(10'd10, 10'd5, 800, found);
    checks++; if (!found || display_en !== 1'b1) begin
      errors++; $display("FAIL mid_frame_reach found=%b de=%b exp 1 1", found, display_en);
    end
    #2 RST = 1'b0;
    #1;
    checks++; if (row !== 10'd0 || col !== 10'd0 || frame_cnt !== 8'd0) begin
      errors++; $display("FAIL async_reset_cnt row=%0d col=%0d cnt=%0d exp 0 0 0", row, col, frame_cnt);
    end
    checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || vnotactive !== 1'b0 || display_en !== 1'b0 ||
                  pix_en !== 1'b0 || frame_start !== 1'b0) begin
      errors++; $display("FAIL async_reset_flags hs=%b vs=%b vna=%b de=%b pe=%b fs=%b exp 1 1 0 0 0 0",
                         hsync, vsync, vnotactive, display_en, pix_en, frame_start);
    end
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    n = 0;
    while (frame_start !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    checks++; if (n != 750 || frame_cnt !== 8'd1) begin
      errors++; $display("FAIL post_reset_frame clk=%0d cnt=%0d exp 750 1", n, frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_line_timing();
    test_vblank_vsync();
    test_frame_rate();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
